// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for the forwarding/interlock unit: operand addresses, writer
// tags and flush in, bypass selects, stall and statistics out.
interface fwd_hazard_unit_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_SRC*REG_AW-1:0] IdRegSrc;
    logic [NUM_SRC-1:0]        IdUsesSrc;
    logic [NUM_SRC*REG_AW-1:0] IdExRegSrc;
    logic                      IdExMemRead;
    logic [REG_AW-1:0]         IdExRegRd;
    logic                      ExMemRegWrite;
    logic [REG_AW-1:0]         ExMemRegRd;
    logic                      MemWbRegWrite;
    logic [REG_AW-1:0]         MemWbRegRd;
    logic                      Flush;
    logic                      CntClear;
    logic [NUM_SRC*2-1:0]      ForwardSel;
    logic                      Stall;
    logic [CNT_W-1:0]          StallCount;
    logic [CNT_W-1:0]          FwdCount;

    modport master (
        output IdRegSrc, IdUsesSrc, IdExRegSrc, IdExMemRead, IdExRegRd,
               ExMemRegWrite, ExMemRegRd, MemWbRegWrite, MemWbRegRd,
               Flush, CntClear,
        input  ForwardSel, Stall, StallCount, FwdCount
    );

    modport slave (
        input  IdRegSrc, IdUsesSrc, IdExRegSrc, IdExMemRead, IdExRegRd,
               ExMemRegWrite, ExMemRegRd, MemWbRegWrite, MemWbRegRd,
               Flush, CntClear,
        output ForwardSel, Stall, StallCount, FwdCount
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand bypass selection, load-use interlock with configurable load latency,
// and saturating stall/forward event counters.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | no interlock in progress; Stall follows the load-use detect
//  WAIT  | stalling for the remaining load latency cycles, rem counts down
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_unit_if.slave  bus
);
    localparam int REM_W = $clog2(LOAD_LAT + 1);
    localparam logic [REM_W-1:0] REM_START = REM_W'(LOAD_LAT - 1);
    localparam logic [REM_W-1:0] REM_ONE   = REM_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                state;
    logic [REM_W-1:0]      rem;
    logic [NUM_SRC*2-1:0]  fwd_sel;
    logic [NUM_SRC-1:0]    use_match;
    logic                  hz;
    logic                  stall;
    logic                  fwd_any;
    logic                  ex_ok;
    logic                  wb_ok;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      fwd_cnt;

    assign ex_ok = bus.ExMemRegWrite && (bus.ExMemRegRd != '0);
    assign wb_ok = bus.MemWbRegWrite && (bus.MemWbRegRd != '0);

    // EX/MEM is the younger result, so it is tested first and wins over MEM/WB.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_ok && (bus.ExMemRegRd == bus.IdExRegSrc[i*REG_AW +: REG_AW])) begin
                fwd_sel[i*2 +: 2] = 2'b10;
            end else if (wb_ok && (bus.MemWbRegRd == bus.IdExRegSrc[i*REG_AW +: REG_AW])) begin
                fwd_sel[i*2 +: 2] = 2'b01;
            end
        end
    end

    assign fwd_any = |fwd_sel;

    always_comb begin
        use_match = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            use_match[i] = bus.IdUsesSrc[i] &&
                           (bus.IdRegSrc[i*REG_AW +: REG_AW] == bus.IdExRegRd);
        end
    end

    assign hz = bus.IdExMemRead && (bus.IdExRegRd != '0) && (|use_match);

    // First stall cycle has to be combinational so the bubble lands on the next edge.
    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    stall = hz && !bus.Flush;
                WAIT:    stall = !bus.Flush;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stall && (LOAD_LAT > 1)) begin
                        state <= WAIT;
                        rem   <= REM_START;
                    end
                end
                WAIT: begin
                    if (bus.Flush || (rem == REM_ONE)) begin
                        state <= IDLE;
                        rem   <= '0;
                    end else begin
                        rem <= rem - REM_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    rem   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (bus.CntClear) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (fwd_any && (fwd_cnt != CNT_MAX)) begin
                fwd_cnt <= fwd_cnt + CNT_ONE;
            end
        end
    end

    assign bus.ForwardSel = fwd_sel;
    assign bus.Stall      = stall;
    assign bus.StallCount = stall_cnt;
    assign bus.FwdCount   = fwd_cnt;
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use interlock unit for the pipelined MIPS core, sitting beside the ID/EX, EX/MEM and MEM/WB pipeline registers. It drives the ALU operand bypass muxes for `NUM_SRC` source operands. It also owns the load-use stall FSM, which supports a configurable data-memory load latency. It keeps saturating statistics counters for stall and forward events.

## Interface
Parameters:
- `REG_AW`, 5: register address width.
- `NUM_SRC`, 2: source operands per instruction (Rs, Rt, ...), each with its own forward select.
- `LOAD_LAT`, 1: stall cycles per load-use hazard; must be ≥1.
- `CNT_W`, 16: statistics counter width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `IdRegSrc`, in, NUM_SRC*REG_AW: source register addresses of the instruction in ID; operand i is at bits [i*REG_AW +: REG_AW].
- `IdUsesSrc`, in, NUM_SRC: per-operand "ID instruction reads this source".
- `IdExRegSrc`, in, NUM_SRC*REG_AW: source register addresses of the instruction in EX.
- `IdExMemRead`, in, 1: EX instruction is a load.
- `IdExRegRd`, in, REG_AW: EX instruction destination.
- `ExMemRegWrite`, in, 1; `ExMemRegRd`, in, REG_AW: EX/MEM writer.
- `MemWbRegWrite`, in, 1; `MemWbRegRd`, in, REG_AW: MEM/WB writer.
- `Flush`, in, 1: branch/jump flush of IF/ID and ID/EX.
- `CntClear`, in, 1: clear statistics counters.
- `ForwardSel`, out, NUM_SRC*2: per-operand select; 2'b00 = register file, 2'b10 = EX/MEM, 2'b01 = MEM/WB.
- `Stall`, out, 1: freeze PC and IF/ID, insert a bubble into ID/EX.
- `StallCount`, out, CNT_W: cycles with `Stall`=1.
- `FwdCount`, out, CNT_W: cycles with any `ForwardSel` ≠ 00.

## Operation
**Forwarding (combinational, per operand i)**
- If `ExMemRegWrite`, `ExMemRegRd` ≠ 0, and `ExMemRegRd` == src_i, select 10.
- Else if `MemWbRegWrite`, `MemWbRegRd` ≠ 0, and `MemWbRegRd` == src_i, select 01.
- Else select 00.
- EX/MEM always wins over MEM/WB when both match.
- Register 0 is never forwarded.

**Hazard detect**
- `hz` = `IdExMemRead` AND `IdExRegRd` ≠ 0 AND there exists an i with `IdUsesSrc[i]` AND `IdRegSrc[i]` == `IdExRegRd`.

**Interlock FSM (states IDLE, WAIT; down-counter `rem` of width clog2(LOAD_LAT+1))**
- IDLE:
  - `Stall` = `hz` AND NOT `Flush`.
  - If `Stall` and LOAD_LAT > 1: go to WAIT with `rem` = LOAD_LAT−1.
  - Otherwise stay in IDLE.
- WAIT:
  - `Stall` = 1; `hz` is ignored, because the pipeline is frozen and ID/EX holds a bubble.
  - `rem` decrements each cycle.
  - When `rem` == 1 the next state is IDLE.
  - `Flush` = 1 in WAIT forces `Stall` = 0 in that cycle, with next state IDLE and `rem` = 0.
- Result: each hazard produces exactly LOAD_LAT consecutive `Stall` cycles unless a flush intervenes.

**Counters**
- Each counter increments by 1 in any cycle its event is true.
- Counters saturate at 2^CNT_W−1.
- `CntClear` zeroes both counters and takes priority over increment.

**Reset (`rst_n` = 0 at a clock edge)**
- State = IDLE, `rem` = 0, `StallCount` = 0, `FwdCount` = 0.
- `Stall` is forced to 0 while `rst_n` = 0.
- `ForwardSel` is purely combinational and is not gated by reset.
- Reset mid-WAIT returns to IDLE; `Stall` is low from that cycle onward.

## Timing
- `ForwardSel` has zero latency and follows its inputs in the same cycle.
- `Stall` is high in the same cycle `hz` is first seen, enabling the ID/EX bubble at the next edge.
- It then stays high for cycles 2..LOAD_LAT (registered WAIT) and is low in cycle LOAD_LAT+1.
- If `hz` is still true in cycle LOAD_LAT+1, a new stall sequence starts. Inputs must not do this in normal operation, because the bubble clears `IdExMemRead`.
- Counters update at the clock edge following the event; the value is visible one cycle later.
- Simultaneous `hz` and `Flush` in IDLE: no stall; `StallCount` does not increment.

## Test plan
- **Forward priority.** NUM_SRC = 2, `IdExRegSrc` = {r3, r3}, `ExMemRegWrite` = 1, `ExMemRegRd` = 3, `MemWbRegWrite` = 1, `MemWbRegRd` = 3 → `ForwardSel` = {10, 10`}. Set `ExMemRegWrite` = 0 → {01, 01}. Set `MemWbRegRd` = 4 → {00, 00}.
- **r0 guard.** All writers target r0 with RegWrite = 1 and sources = r0 → `ForwardSel` = 0. `IdExRegRd` = 0 with a load → no `Stall`.
- **Load-use, LOAD_LAT = 1.** `IdExMemRead` = 1, `IdExRegRd` = 5, `IdRegSrc[1]` = 5, `IdUsesSrc` = 2'b10 → `Stall` high for 1 cycle only. Repeat with `IdUsesSrc` = 2'b01 → no stall.
- **LOAD_LAT = 3 with a flush.** Hazard at cycle 0 → `Stall` = 1 in cycles 0–2 and 0 in cycle 3; `StallCount` = 3. Repeat with `Flush` pulsed at cycle 1 → `Stall` = 1 in cycle 0 only; state IDLE at cycle 2.
- **Counter saturation and clear.** CNT_W = 4; hold a forward condition for 20 cycles → `FwdCount` = 15. Assert `CntClear` while the condition persists → `FwdCount` = 0 the next cycle, then 1.
- **Reset mid-WAIT.** LOAD_LAT = 4, hazard at cycle 0, `rst_n` = 0 at cycle 2 → `Stall` = 0 from cycle 2. After reset is released: state IDLE, both counters 0.
